// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter:
// register map, transmit FSM encoding and STATUS bit layout.
package uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

    // A divider of zero would stall the baud counter, so it is stored as one.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full and
// pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/dmem_uart_tx.sv
// UART transmitter on the data-memory bus: 16-byte window with
// TXDATA/STATUS/BAUDDIV registers and an 8N1 serializer.
module dmem_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE        = 32'h10018000,
    parameter int          DEPTH       = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        ena,
    input  logic        we,
    inout  wire  [31:0] data,
    output logic        tx
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic        sel, wr, rd;
    logic [1:0]  ridx;
    logic [31:0] rdata;

    logic        push, pop;
    logic [7:0]  fifo_rdata;
    logic        full, empty;
    logic [CW-1:0] count;

    logic        ovf_q, ovf_d;
    logic [15:0] div_q, div_d;

    logic [1:0]  state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] cdiv_q, cdiv_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic        tx_q, tx_d;
    logic        load;

    logic        unused_bits;

    assign sel  = ena & (addr[31:4] == BASE[31:4]);
    assign ridx = addr[3:2];
    assign wr   = sel & we;
    assign rd   = sel & ~we;
    assign push = wr & (ridx == REG_TXDATA);

    assign unused_bits = ^{addr[1:0], data[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_i   (reset),
        .push_i  (push),
        .wdata_i (data[7:0]),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        ovf_d = ovf_q;
        div_d = div_q;
        if (wr && ridx == REG_STATUS) ovf_d = 1'b0;
        else if (push && full)        ovf_d = 1'b1;
        if (wr && ridx == REG_BAUDDIV) div_d = clamp_div(data[15:0]);
    end

    always_comb begin
        rdata = '0;
        unique case (ridx)
            REG_STATUS: begin
                rdata[STAT_FULL]            = full;
                rdata[STAT_EMPTY]           = empty;
                rdata[STAT_BUSY]            = (state_q != S_IDLE);
                rdata[STAT_OVF]             = ovf_q;
                rdata[STAT_CNT_LSB +: CW]   = count;
            end
            REG_BAUDDIV: rdata[15:0] = div_q;
            default:     rdata = '0;
        endcase
    end

    assign data = rd ? rdata : 32'bz;
    assign tx   = tx_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cdiv_d  = cdiv_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE: load = ~empty;
            S_START: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    cnt_d   = cdiv_q - 16'd1;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = cdiv_q - 16'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[bit_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                // Chain straight into the next frame when data is waiting.
                if (cnt_q == '0) begin
                    if (empty) state_d = S_IDLE;
                    else       load    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            state_d = S_START;
            shift_d = fifo_rdata;
            cdiv_d  = div_q;
            cnt_d   = div_q - 16'd1;
            tx_d    = 1'b0;
        end
    end

    assign pop = load;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            ovf_q   <= 1'b0;
            div_q   <= DEFAULT_DIV;
            state_q <= S_IDLE;
            shift_q <= '0;
            cdiv_q  <= DEFAULT_DIV;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            ovf_q   <= ovf_d;
            div_q   <= div_d;
            state_q <= state_d;
            shift_q <= shift_d;
            cdiv_q  <= cdiv_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_dmem_uart_tx.sv
// Directed bench for dmem_uart_tx: bus register access plus a
// line monitor that decodes 8N1 frames from the tx pin.
module tb_dmem_uart_tx;

    localparam logic [31:0] BASE = 32'h10018000;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic [31:0] addr   = '0;
    logic        ena    = 1'b0;
    logic        we     = 1'b0;
    logic [31:0] drv    = '0;
    logic        drv_en = 1'b0;
    wire  [31:0] data_bus;
    logic        tx;

    assign data_bus = drv_en ? drv : 32'bz;
    pullup (data_bus);

    dmem_uart_tx #(
        .BASE        (BASE),
        .DEPTH       (16),
        .DEFAULT_DIV (16'd868)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .addr   (addr),
        .ena    (ena),
        .we     (we),
        .data   (data_bus),
        .tx     (tx)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk_in);
        addr = a; ena = 1'b1; we = 1'b1; drv = d; drv_en = 1'b1;
        @(posedge clk_in);
        #1;
        ena = 1'b0; we = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk_in);
        addr = a; ena = 1'b1; we = 1'b0;
        #1;
        d = data_bus;
        ena = 1'b0;
    endtask

    // Line monitor: bit length latched from mon_div at each start bit.
    int         mon_div = 4;
    logic [7:0] rx_q[$];
    int         start_q[$];
    int         frame_err = 0;
    int         mon_d, mon_st, mon_k;
    logic       mon_s[$];
    logic [7:0] mon_b;
    logic       mon_e;
    bit         mon_abort;

    initial forever begin
        @(negedge clk_in);
        if (!reset && tx === 1'b0) begin
            mon_d = mon_div;
            mon_st = cyc;
            mon_abort = 1'b0;
            mon_s.delete();
            mon_s.push_back(tx);
            for (int c = 1; c < 10 * mon_d; c++) begin
                @(negedge clk_in);
                if (reset) begin
                    mon_abort = 1'b1;
                    break;
                end
                mon_s.push_back(tx);
            end
            if (!mon_abort) begin
                for (int j = 0; j < 8; j++) mon_b[j] = mon_s[(j + 1) * mon_d];
                for (int c = 0; c < 10 * mon_d; c++) begin
                    mon_k = c / mon_d;
                    if (mon_k == 0)      mon_e = 1'b0;
                    else if (mon_k == 9) mon_e = 1'b1;
                    else                 mon_e = mon_b[mon_k - 1];
                    if (mon_s[c] !== mon_e) frame_err++;
                end
                rx_q.push_back(mon_b);
                start_q.push_back(mon_st);
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] st0, st1;
        logic        tx0, tx1;
        int          busy_n, n0, zeros;

        repeat (3) @(posedge clk_in);
        #1;
        chk("tx_in_reset", 32'(tx), 32'd1);
        @(negedge clk_in);
        reset = 1'b0;

        bus_read(BASE + 32'd4, r);
        chk("status_reset", r, 32'h00000002);
        bus_read(BASE + 32'd8, r);
        chk("bauddiv_reset", r, 32'd868);
        bus_read(BASE, r);
        chk("txdata_reads_zero", r, 32'h0);
        @(negedge clk_in);
        addr = BASE + 32'd4; ena = 1'b0; we = 1'b0;
        #1;
        chk("bus_released_ena0", data_bus, 32'hFFFFFFFF);
        chk("tx_idle", 32'(tx), 32'd1);

        bus_write(BASE + 32'd8, 32'd0);
        bus_read(BASE + 32'd8, r);
        chk("bauddiv_zero_clamped", r, 32'd1);
        bus_write(BASE + 32'd8, 32'd4);
        bus_read(BASE + 32'd8, r);
        chk("bauddiv_4", r, 32'd4);

        // Single frame 0x55 at DIV=4.
        mon_div = 4;
        bus_write(BASE, 32'h55);
        busy_n = 0; st0 = '0; st1 = '0; tx0 = 1'b0; tx1 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            bus_read(BASE + 32'd4, r);
            if (i == 0) begin st0 = r; tx0 = tx; end
            if (i == 1) begin st1 = r; tx1 = tx; end
            busy_n += int'(r[2]);
        end
        chk("status_after_push", st0, 32'h00000100);
        chk("status_after_pop", st1, 32'h00000006);
        chk("tx_before_start", 32'(tx0), 32'd1);
        chk("tx_start_bit", 32'(tx1), 32'd0);
        chk("busy_cycles", busy_n, 32'd40);
        chk("frame55_count", rx_q.size(), 32'd1);
        chk("frame55_byte", 32'(rx_q[0]), 32'h55);
        rx_q.delete();
        start_q.delete();

        // Overflow: 17 pushes while the serializer is busy.
        bus_write(BASE, 32'hA5);
        for (int i = 0; i < 17; i++) bus_write(BASE, 32'(i));
        bus_read(BASE + 32'd4, r);
        chk("status_overflow", r, 32'h0000100D);
        bus_write(BASE + 32'd4, 32'hFFFFFFFF);
        bus_read(BASE + 32'd4, r);
        chk("status_ovf_cleared", r, 32'h00001005);
        n0 = 0;
        while (rx_q.size() < 17 && n0 < 2000) begin
            @(negedge clk_in);
            n0++;
        end
        chk("ovf_drain_in_time", 32'(n0 < 2000), 32'd1);
        repeat (100) @(negedge clk_in);
        chk("ovf_frame_count", rx_q.size(), 32'd17);
        chk("ovf_first_byte", 32'(rx_q[0]), 32'hA5);
        for (int i = 0; i < 16; i++)
            chk($sformatf("ovf_byte_%0d", i), 32'(rx_q[i + 1]), 32'(i));
        bus_read(BASE + 32'd4, r);
        chk("status_drained", r, 32'h00000002);
        rx_q.delete();
        start_q.delete();

        // Divider change mid-frame applies to the next frame only.
        bus_write(BASE, 32'h0F);
        bus_write(BASE, 32'hF0);
        repeat (8) @(negedge clk_in);
        bus_write(BASE + 32'd8, 32'd2);
        mon_div = 2;
        n0 = 0;
        while (rx_q.size() < 2 && n0 < 500) begin
            @(negedge clk_in);
            n0++;
        end
        chk("divchg_in_time", 32'(n0 < 500), 32'd1);
        chk("divchg_frame1", 32'(rx_q[0]), 32'h0F);
        chk("divchg_frame2", 32'(rx_q[1]), 32'hF0);
        chk("back_to_back_gap", 32'(start_q[1] - start_q[0]), 32'd40);
        repeat (10) @(negedge clk_in);
        rx_q.delete();
        start_q.delete();

        // Reset in the DATA state with three bytes still queued.
        bus_write(BASE + 32'd8, 32'd4);
        mon_div = 4;
        bus_write(BASE, 32'h11);
        bus_write(BASE, 32'h22);
        bus_write(BASE, 32'h33);
        bus_write(BASE, 32'h44);
        repeat (7) @(negedge clk_in);
        chk("tx_mid_frame", 32'(tx), 32'd0);
        reset = 1'b1;
        #1;
        chk("tx_async_reset", 32'(tx), 32'd1);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        bus_read(BASE + 32'd4, r);
        chk("status_after_reset", r, 32'h00000002);
        bus_read(BASE + 32'd8, r);
        chk("bauddiv_after_reset", r, 32'd868);
        zeros = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (tx !== 1'b1) zeros++;
        end
        chk("tx_quiet_after_reset", zeros, 32'd0);
        chk("no_frames_after_reset", rx_q.size(), 32'd0);

        // Address decode.
        bus_read(32'h10010000, r);
        chk("unselected_read", r, 32'hFFFFFFFF);
        bus_read(32'h1001800C, r);
        chk("reg3_read", r, 32'h0);
        bus_write(32'h1001800C, 32'hDEADBEEF);
        bus_read(32'h1001800C, r);
        chk("reg3_write_ignored", r, 32'h0);
        bus_read(32'h10018006, r);
        chk("low_addr_bits_ignored", r, 32'h00000002);
        bus_write(32'h10010008, 32'd7);
        bus_read(BASE + 32'd8, r);
        chk("unselected_write", r, 32'd868);

        chk("frame_errors", frame_err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_uart_tx.md
# dmem_uart_tx

Memory-mapped UART transmitter that responds on the CPU31 data-memory port, alongside the data RAM, at the I/O window `BASE` (default 0x10018000). The CPU stores bytes into a 16-entry transmit FIFO and polls status through ordinary `sw`/`lw`. A serializer drains the FIFO onto the `tx` pin as 8N1 frames, LSB first. The top level routes `addr_dmem`/`data_dmem`/`wea_dmem` to both this block and the RAM. This block drives the shared data bus only for reads inside its own window.

## Interface
- `BASE`, 32'h10018000: byte address of register 0; the window is 16 bytes.
- `DEPTH`, 16: FIFO entries; must be a power of two.
- `DEFAULT_DIV`, 16'd868: reset value of BAUDDIV (115200 baud at 100 MHz).
- `clk_in`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `addr`  in  32  CPU byte address (raw `addr_dmem`, not offset-mapped).
- `ena`  in  1  access enable.
- `we`  in  1  write strobe; 1 = store, 0 = load.
- `data`  inout  32  shared data bus; driven only when `sel & ~we`, otherwise high-Z.
- `tx`  out  1  serial line, idle high.

## Operation
- `sel` = `ena` and `addr[31:4] == BASE[31:4]`. The register index is `addr[3:2]`; `addr[1:0]` is ignored.
- Register 0, TXDATA:
  - Write: pushes `data[7:0]` into the FIFO.
  - Read: returns 0.
- Register 1, STATUS (read-only fields):
  - bit0 = full, bit1 = empty, bit2 = busy (FSM not IDLE), bit3 = overflow (sticky).
  - bits[12:8] = FIFO count (0..16); all other bits read 0.
  - Any write to STATUS clears overflow.
- Register 2, BAUDDIV: read/write, 16 bits, zero-extended on read. A written value of 0 is stored as 1.
- Register 3: reads 0; writes are ignored.
- A push while full is dropped, FIFO contents are unchanged, and overflow is set. Fullness is evaluated before any same-cycle pop, so a push is dropped even when a pop happens in the same cycle.
- Transmit FSM states:
  - IDLE: `tx` = 1. If the FIFO is non-empty: pop into the shift register, latch BAUDDIV into `cur_div`, go to START.
  - START: `tx` = 0 for `cur_div` cycles, then go to DATA with bit index 0.
  - DATA: `tx` = `shift[idx]` for `cur_div` cycles per bit. After idx = 7, go to STOP.
  - STOP: `tx` = 1 for `cur_div` cycles, then return to IDLE. IDLE may pop again on the very next edge, so back-to-back frames have no extra idle cycles.
- A BAUDDIV write during a frame takes effect from the next frame only.
- Reset values:
  - FIFO empty, read and write pointers 0, count 0.
  - overflow = 0, BAUDDIV = `DEFAULT_DIV`.
  - FSM in IDLE, `tx` = 1 (registered output), `data` = high-Z.
- Reset mid-frame aborts the frame immediately: `tx` goes to 1 asynchronously and queued bytes are discarded.

## Timing
- Reads are combinational, matching the data RAM: `data` is valid in the same cycle that `sel & ~we` is asserted.
- Writes are sampled on the `clk_in` edge where `sel & we` = 1.
- A push at edge k into an empty FIFO with FSM IDLE:
  - edge k+1: pop and enter START; `tx` = 0 from k+1.
  - frame length: 10 × `cur_div` cycles.
- STATUS reflects the updated count from the edge after a push or pop.
- Simultaneous push (not full) and pop: count is unchanged; both pointers advance and wrap modulo `DEPTH`.
- The baud counter counts `cur_div`−1 down to 0; a bit ends when the counter reaches 0.

## Structure
- Package `uart_pkg`:
  - register index constants REG_TXDATA = 0, REG_STATUS = 1, REG_BAUDDIV = 2;
  - FSM state encoding IDLE/START/DATA/STOP (2 bits);
  - STATUS bit positions.
- Sub-module `sync_fifo`:
  - parameters width 8 and `DEPTH`;
  - ports for push, pop, full, empty, count;
  - async active-high reset.
- Top-level integration adds a second instance on the dmem bus. RAM and UART windows do not overlap, so at most one driver is enabled at a time.

## Test plan
- Reset, then read STATUS → 0x00000002. Read BAUDDIV → 868. `tx` = 1 and `data` is Z when `sel` = 0.
- Write BAUDDIV = 4, then TXDATA = 0x55 → `tx` sequence is 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. The start bit begins one edge after the write. busy = 1 for exactly 40 cycles.
- With the FSM busy, write 17 bytes 0x00..0x10 → STATUS = 0x0000100D (count 16, full, busy, overflow). The transmitted stream contains 0x00..0x0F only. A write to STATUS then clears bit3.
- Write BAUDDIV = 2 in the middle of a DIV=4 frame → the current frame keeps 4-cycle bits; the next queued frame uses 2-cycle bits.
- Assert `reset` during the DATA state of a frame with 3 bytes queued → `tx` = 1 immediately, STATUS = 0x2 after release, and no further frames are sent.
- Read addresses 0x10010000 and 0x1001800C → first: bus Z (not selected); second: 0.
